pe_cluster_ctrl: RTL and testbench

Sequencer for the 16-PE convolution cluster. It accepts a job (accumulation length per output pixel, pixel count, active-PE mask), streams IFM words into the cluster, gates `PE_en`, pulses `PE_finish` at the end of each accumulation, waits for the PEs' `valid`, and hands each OFM pixel group to the write-back path. It sits between the layer-level controller/buffers and the PE cluster datapath.

---
 rtl/pe_cluster_ctrl_if.sv | 39 +++
 rtl/pe_cluster_ctrl.sv | 118 +++++++++++
 tb/tb_pe_cluster_ctrl.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pe_cluster_ctrl_if.sv
// Handshake and bus bundle between the PE cluster sequencer and its surroundings
// (job config, IFM stream, PE control/status, OFM write-back).
`timescale 1ns/1ps
interface pe_cluster_ctrl_if #(
    parameter int NUM_PE = 16,
    parameter int CNT_W  = 16,
    parameter int ADDR_W = 16
);
    logic              start;
    logic              abort;
    logic [CNT_W-1:0]  cfg_num_mac;
    logic [CNT_W-1:0]  cfg_num_pix;
    logic [NUM_PE-1:0] cfg_pe_mask;
    logic              ifm_valid;
    logic              ifm_rd_en;
    logic [ADDR_W-1:0] ifm_addr;
    logic [ADDR_W-1:0] wgt_addr;
    logic [NUM_PE-1:0] PE_en;
    logic [NUM_PE-1:0] PE_finish;
    logic [NUM_PE-1:0] pe_valid;
    logic              ofm_wr_en;
    logic              ofm_ready;
    logic              busy;
    logic              done;

    // master = the sequencer, slave = controller/buffers/cluster side
    modport master (
        input  start, abort, cfg_num_mac, cfg_num_pix, cfg_pe_mask,
               ifm_valid, pe_valid, ofm_ready,
        output ifm_rd_en, ifm_addr, wgt_addr, PE_en, PE_finish,
               ofm_wr_en, busy, done
    );
    modport slave (
        output start, abort, cfg_num_mac, cfg_num_pix, cfg_pe_mask,
               ifm_valid, pe_valid, ofm_ready,
        input  ifm_rd_en, ifm_addr, wgt_addr, PE_en, PE_finish,
               ofm_wr_en, busy, done
    );
endinterface

// File: rtl/pe_cluster_ctrl.sv
// Job sequencer for the PE convolution cluster: streams IFM words per output pixel,
// gates/finishes the PEs, waits for results and hands each pixel group to write-back.
`timescale 1ns/1ps
module pe_cluster_ctrl #(
    parameter int NUM_PE = 16,
    parameter int CNT_W  = 16,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    pe_cluster_ctrl_if.master bus
);
    typedef enum logic [2:0] {IDLE, RUN, FINISH, WAIT_V, OUT, DONE} state_t;

    state_t            state_reg, state_next;
    logic [NUM_PE-1:0] mask_reg;
    logic [CNT_W-1:0]  num_mac_reg, num_pix_reg;
    logic [CNT_W-1:0]  mac_cnt_reg, pix_cnt_reg;
    logic [ADDR_W-1:0] ifm_addr_reg;

    logic              ifm_xfer, ofm_xfer, last_mac, last_pix, all_valid;
    logic [NUM_PE-1:0] pe_ok;

    // An unmasked PE never holds up the result wait.
    generate
        for (genvar gi = 0; gi < NUM_PE; gi++) begin : g_pe_ok
            assign pe_ok[gi] = ~mask_reg[gi] | bus.pe_valid[gi];
        end
    endgenerate

    assign all_valid = &pe_ok;
    assign ifm_xfer  = (state_reg == RUN) & bus.ifm_valid;
    assign ofm_xfer  = (state_reg == OUT) & bus.ofm_ready;
    assign last_mac  = (mac_cnt_reg == num_mac_reg - CNT_W'(1));
    assign last_pix  = (pix_cnt_reg == num_pix_reg - CNT_W'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_reg <= IDLE;
        else          state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        if (bus.abort) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:    if (bus.start) state_next = (bus.cfg_num_pix == '0) ? DONE : RUN;
                RUN:     if (ifm_xfer && last_mac) state_next = FINISH;
                FINISH:  state_next = WAIT_V;
                WAIT_V:  if (all_valid) state_next = OUT;
                OUT:     if (bus.ofm_ready) state_next = last_pix ? DONE : RUN;
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Config and counters; ifm_addr deliberately keeps running across pixels.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_reg     <= '0;
            num_mac_reg  <= '0;
            num_pix_reg  <= '0;
            mac_cnt_reg  <= '0;
            pix_cnt_reg  <= '0;
            ifm_addr_reg <= '0;
        end else if (bus.abort) begin
            mac_cnt_reg  <= '0;
            pix_cnt_reg  <= '0;
            ifm_addr_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        mask_reg     <= bus.cfg_pe_mask;
                        num_mac_reg  <= (bus.cfg_num_mac == '0) ? CNT_W'(1) : bus.cfg_num_mac;
                        num_pix_reg  <= bus.cfg_num_pix;
                        mac_cnt_reg  <= '0;
                        pix_cnt_reg  <= '0;
                        ifm_addr_reg <= '0;
                    end
                end
                RUN: begin
                    if (ifm_xfer) begin
                        mac_cnt_reg  <= last_mac ? '0 : mac_cnt_reg + CNT_W'(1);
                        ifm_addr_reg <= ifm_addr_reg + ADDR_W'(1);
                    end
                end
                OUT: begin
                    if (ofm_xfer) pix_cnt_reg <= pix_cnt_reg + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.ifm_rd_en = 1'b0;
        bus.PE_en     = '0;
        bus.PE_finish = '0;
        bus.ofm_wr_en = 1'b0;
        bus.done      = 1'b0;
        bus.busy      = (state_reg != IDLE);
        bus.ifm_addr  = ifm_addr_reg;
        bus.wgt_addr  = ADDR_W'(mac_cnt_reg);
        case (state_reg)
            RUN: begin
                bus.ifm_rd_en = 1'b1;
                if (bus.ifm_valid) bus.PE_en = mask_reg;
            end
            FINISH:  bus.PE_finish = mask_reg;
            OUT:     bus.ofm_wr_en = 1'b1;
            DONE:    bus.done = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_pe_cluster_ctrl.sv
// Directed bench for pe_cluster_ctrl: one linear stimulus sequence, immediate assertions
// against hand-computed cycle counts, enables, addresses and completion timing.
`timescale 1ns/1ps
module tb_pe_cluster_ctrl;
    localparam int NUM_PE = 16;
    localparam int CNT_W  = 16;
    localparam int ADDR_W = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    pe_cluster_ctrl_if #(.NUM_PE(NUM_PE), .CNT_W(CNT_W), .ADDR_W(ADDR_W)) bus();

    pe_cluster_ctrl #(.NUM_PE(NUM_PE), .CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // pe_valid either echoes PE_finish one cycle later or is driven directly
    logic              echo_mode = 1'b1;
    logic [NUM_PE-1:0] pe_valid_man = '0;
    logic [NUM_PE-1:0] echo_q = '0;
    always @(posedge clk) echo_q <= bus.PE_finish;
    assign bus.pe_valid = echo_mode ? echo_q : pe_valid_man;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Activity counters sampled mid-cycle
    int en_n = 0, fin_n = 0, wr_n = 0, done_n = 0, gap_n = 0;
    logic prev_en = 1'b0;
    logic [NUM_PE-1:0] last_en = '0, last_fin = '0;
    logic [ADDR_W-1:0] wq[$];
    always @(negedge clk) begin
        if (|bus.PE_en) begin
            en_n    <= en_n + 1;
            last_en <= bus.PE_en;
            wq.push_back(bus.wgt_addr);
        end
        if (|bus.PE_finish) begin
            fin_n    <= fin_n + 1;
            last_fin <= bus.PE_finish;
            if (!prev_en) gap_n <= gap_n + 1;
        end
        if (bus.ofm_wr_en) wr_n <= wr_n + 1;
        if (bus.done) done_n <= done_n + 1;
        prev_en <= |bus.PE_en;
    end

    int passed = 0;
    int total  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(output int t);
        bus.start = 1'b1;
        t = cyc;
        step();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int limit, input bit tog, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            if (bus.done === 1'b1) begin
                at = cyc;
                break;
            end
            step();
            if (tog) bus.ifm_valid = ~bus.ifm_valid;
        end
    endtask

    task automatic cfg(input int nmac, input int npix, input logic [NUM_PE-1:0] mask);
        bus.cfg_num_mac = CNT_W'(nmac);
        bus.cfg_num_pix = CNT_W'(npix);
        bus.cfg_pe_mask = mask;
    endtask

    initial begin
        int t, at, e0, f0, w0, d0, g0, base, n;
        bus.start = 0; bus.abort = 0; bus.ifm_valid = 0; bus.ofm_ready = 0;
        cfg(0, 0, '0);

        // Reset state
        #2;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_rd_en", bus.ifm_rd_en, 0);
        chk("rst_wr_en", bus.ofm_wr_en, 0);
        chk("rst_pe_en", bus.PE_en, 0);
        chk("rst_pe_finish", bus.PE_finish, 0);
        chk("rst_ifm_addr", bus.ifm_addr, 0);
        chk("rst_wgt_addr", bus.wgt_addr, 0);
        step(); reset_n = 1'b1; step();

        // Basic job: 4 MACs x 2 pixels, no stalls, done 15 cycles after start
        cfg(4, 2, 16'hFFFF); bus.ifm_valid = 1; bus.ofm_ready = 1; echo_mode = 1;
        e0 = en_n; f0 = fin_n; w0 = wr_n; d0 = done_n; g0 = gap_n;
        start_job(t);
        chk("t1_run_busy", bus.busy, 1);
        chk("t1_run_pe_en", bus.PE_en, 16'hFFFF);
        cfg(9, 9, 16'h0001);
        wait_done(60, 0, at);
        chk("t1_done_cycle", at - t, 15);
        step();
        chk("t1_en_cycles", en_n - e0, 8);
        chk("t1_finish_cycles", fin_n - f0, 2);
        chk("t1_wr_cycles", wr_n - w0, 2);
        chk("t1_done_count", done_n - d0, 1);
        chk("t1_finish_gap", gap_n - g0, 0);
        chk("t1_ifm_addr", bus.ifm_addr, 8);
        chk("t1_idle", bus.busy, 0);

        // ifm_valid toggling: enables only on valid cycles, wgt_addr 0..3 per pixel
        cfg(4, 2, 16'hFFFF); bus.ifm_valid = 1;
        e0 = en_n; g0 = gap_n; base = wq.size();
        start_job(t);
        wait_done(80, 1, at);
        chk("t2_done_seen", (at >= 0), 1);
        step();
        chk("t2_en_cycles", en_n - e0, 8);
        chk("t2_finish_gap", gap_n - g0, 0);
        chk("t2_ifm_addr", bus.ifm_addr, 8);
        n = wq.size() - base;
        chk("t2_wgt_count", n, 8);
        for (int i = 0; i < 8 && i < n; i++) chk($sformatf("t2_wgt_addr%0d", i), wq[base + i], i % 4);
        bus.ifm_valid = 1;

        // Partial mask, WAIT_V held for 5 cycles by an unfinished masked PE
        cfg(2, 1, 16'h00F0); echo_mode = 0; pe_valid_man = 16'h0070;
        start_job(t);
        for (int i = 0; i < 10 && !(|bus.PE_finish); i++) step();
        chk("t3_pe_finish", bus.PE_finish, 16'h00F0);
        chk("t3_pe_en", last_en, 16'h00F0);
        for (int k = 1; k <= 5; k++) begin
            step();
            chk($sformatf("t3_wait_hold%0d", k),
                {bus.busy, bus.ifm_rd_en, bus.ofm_wr_en, |bus.PE_finish}, 4'b1000);
        end
        pe_valid_man = 16'h00F0;
        step();
        chk("t3_out_after_valid", bus.ofm_wr_en, 1);
        wait_done(20, 0, at);
        chk("t3_done_cycle", at - t, 10);
        step();

        // Write-back backpressure for 3 cycles; start while busy is ignored
        cfg(1, 2, 16'hFFFF); echo_mode = 1; bus.ofm_ready = 0;
        w0 = wr_n; d0 = done_n; e0 = en_n;
        start_job(t);
        for (int i = 0; i < 10 && !bus.ofm_wr_en; i++) step();
        chk("t4_out1", bus.ofm_wr_en, 1);
        bus.start = 1; step(); bus.start = 0;
        chk("t4_out2", bus.ofm_wr_en, 1);
        step();
        chk("t4_out3", bus.ofm_wr_en, 1);
        step();
        chk("t4_out4", bus.ofm_wr_en, 1);
        bus.ofm_ready = 1;
        step();
        chk("t4_back_to_run", {bus.ifm_rd_en, bus.ofm_wr_en}, 2'b10);
        wait_done(20, 0, at);
        chk("t4_done_cycle", at - t, 12);
        step();
        chk("t4_wr_cycles", wr_n - w0, 5);
        chk("t4_done_count", done_n - d0, 1);
        chk("t4_en_cycles", en_n - e0, 2);
        chk("t4_ifm_addr", bus.ifm_addr, 2);
        chk("t4_idle", bus.busy, 0);

        // Zero pixels: straight to DONE the cycle after start
        cfg(3, 0, 16'hFFFF); e0 = en_n;
        start_job(t);
        chk("t5_done", {bus.done, bus.busy, bus.ifm_rd_en}, 3'b110);
        step();
        chk("t5_idle", {bus.done, bus.busy}, 2'b00);
        chk("t5_no_en", en_n - e0, 0);

        // num_mac = 0 behaves as 1
        cfg(0, 1, 16'hFFFF); e0 = en_n; f0 = fin_n;
        start_job(t);
        wait_done(20, 0, at);
        chk("t6_done_cycle", at - t, 5);
        step();
        chk("t6_en_cycles", en_n - e0, 1);
        chk("t6_finish_cycles", fin_n - f0, 1);
        chk("t6_ifm_addr", bus.ifm_addr, 1);

        // Abort in WAIT_V
        cfg(1, 1, 16'hFFFF); echo_mode = 0; pe_valid_man = '0; d0 = done_n;
        start_job(t);
        step();
        chk("t7_finish", bus.PE_finish, 16'hFFFF);
        step();
        chk("t7_in_wait", {bus.busy, bus.ofm_wr_en}, 2'b10);
        bus.abort = 1; step(); bus.abort = 0;
        chk("t7_abort_idle", bus.busy, 0);
        chk("t7_abort_addr", bus.ifm_addr, 0);
        repeat (4) step();
        chk("t7_no_done", done_n - d0, 0);

        // Abort together with start: stays IDLE
        cfg(2, 1, 16'hFFFF);
        bus.start = 1; bus.abort = 1; step(); bus.start = 0; bus.abort = 0;
        chk("t8_start_abort", {bus.busy, bus.ifm_rd_en}, 2'b00);

        // All-zero mask sequences normally with PEs untouched
        cfg(2, 1, 16'h0000); pe_valid_man = '0; e0 = en_n; f0 = fin_n; w0 = wr_n;
        start_job(t);
        wait_done(20, 0, at);
        chk("t9_done_cycle", at - t, 6);
        step();
        chk("t9_no_en", en_n - e0, 0);
        chk("t9_no_finish", fin_n - f0, 0);
        chk("t9_wr_cycles", wr_n - w0, 1);

        // Asynchronous reset mid-RUN, then a fresh job
        cfg(8, 1, 16'hFFFF); echo_mode = 1;
        start_job(t);
        step();
        chk("t10_running", bus.ifm_rd_en, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("t10_rst_outputs",
            {bus.busy, bus.ifm_rd_en, bus.ofm_wr_en, bus.done, |bus.PE_en, |bus.PE_finish}, 6'b0);
        chk("t10_rst_addrs", {bus.ifm_addr, bus.wgt_addr}, 32'h0);
        step(); reset_n = 1'b1; step();
        cfg(1, 1, 16'hFFFF);
        start_job(t);
        wait_done(20, 0, at);
        chk("t10_fresh_done_cycle", at - t, 5);
        step();
        chk("t10_fresh_ifm_addr", bus.ifm_addr, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish by 200000ns");
        $fatal(1);
    end
endmodule
